// File: rtl/sat_pkg.sv
// Shared types and sizing for the clause loader.
// Encoded literal is {var-1, neg}.
package sat_pkg;

    localparam int MAX_VARS       = 256;
    localparam int MAX_CLAUSES    = 256;
    localparam int MAX_LITS       = 2048;
    localparam int MAX_CLAUSE_LEN = 16;

    localparam int VAR_W = $clog2(MAX_VARS);
    localparam int LA_W  = $clog2(MAX_LITS);
    localparam int CA_W  = $clog2(MAX_CLAUSES);
    localparam int LEN_W = $clog2(MAX_CLAUSE_LEN + 1);
    localparam int NC_W  = $clog2(MAX_CLAUSES + 1);
    localparam int NL_W  = $clog2(MAX_LITS + 1);
    localparam int MV_W  = $clog2(MAX_VARS + 1);

    typedef struct packed {
        logic [VAR_W-1:0] vidx;
        logic             neg;
    } lit_enc_t;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_ZERO    = 3'd1,
        ERR_RANGE   = 3'd2,
        ERR_LIT_OVF = 3'd3,
        ERR_LEN_OVF = 3'd4,
        ERR_CLS_OVF = 3'd5,
        ERR_UNTERM  = 3'd6
    } err_e;

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_FROZEN = 2'd1,
        S_ERROR  = 2'd2
    } state_e;

    function automatic lit_enc_t enc_lit(input int lit);
        logic [31:0] mag;
        lit_enc_t    e;
        mag    = (lit < 0) ? 32'(-lit) : 32'(lit);
        mag    = mag - 32'd1;
        e.vidx = mag[VAR_W-1:0];
        e.neg  = (lit < 0);
        return e;
    endfunction

endpackage

// File: rtl/lit_check.sv
// Combinational validation of one incoming literal.
// Reports the highest-priority error and |lit|.
module lit_check
    import sat_pkg::*;
(
    input  logic [31:0]     i_literal,
    input  logic [NL_W-1:0] i_num_lits,
    input  logic [NC_W-1:0] i_num_clauses,
    input  logic [LEN_W-1:0] i_open_len,
    input  logic            i_clause_end,
    output err_e            o_err,
    output logic [MV_W-1:0] o_abs
);

    logic [31:0] w_mag;

    // -2^31 negates to itself and so still fails the range check
    assign w_mag = i_literal[31] ? (~i_literal + 32'd1) : i_literal;
    assign o_abs = w_mag[MV_W-1:0];

    // Error priority: value problems first, then capacity problems
    always_comb begin
        o_err = ERR_NONE;
        if (i_literal == 32'd0)
            o_err = ERR_ZERO;
        else if (w_mag > 32'(MAX_VARS))
            o_err = ERR_RANGE;
        else if (i_num_lits == NL_W'(MAX_LITS))
            o_err = ERR_LIT_OVF;
        else if (i_open_len == LEN_W'(MAX_CLAUSE_LEN))
            o_err = ERR_LEN_OVF;
        else if (i_clause_end && i_num_clauses == NC_W'(MAX_CLAUSES))
            o_err = ERR_CLS_OVF;
    end

endmodule

// File: rtl/clause_load_rx.sv
// Receiver for the host literal-load stream: encodes literals,
// writes literal memory and clause table, freezes on start_solve.
module clause_load_rx
    import sat_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load_clear,
    input  logic               load_valid,
    input  logic [31:0]        load_literal,
    input  logic               load_clause_end,
    output logic               load_ready,
    input  logic               start_solve,
    output logic               lit_we,
    output logic [LA_W-1:0]    lit_waddr,
    output logic [VAR_W:0]     lit_wdata,
    output logic               cls_we,
    output logic [CA_W-1:0]    cls_waddr,
    output logic [LA_W-1:0]    cls_start,
    output logic [LEN_W-1:0]   cls_len,
    output logic [NC_W-1:0]    num_clauses,
    output logic [NL_W-1:0]    num_lits,
    output logic [MV_W-1:0]    max_var,
    output logic               load_done,
    output logic               load_error,
    output logic [2:0]         err_code
);

    state_e            r_state;
    state_e            w_next;
    err_e              w_chk_err;
    err_e              w_err;
    logic [MV_W-1:0]   w_abs;
    logic              w_acc;
    logic              w_acc_ok;
    logic [LEN_W-1:0]  w_len_nxt;

    logic              r_ready;
    logic              r_lit_we;
    logic [LA_W-1:0]   r_lit_waddr;
    lit_enc_t          r_lit_wdata;
    logic              r_cls_we;
    logic [CA_W-1:0]   r_cls_waddr;
    logic [LA_W-1:0]   r_cls_start;
    logic [LEN_W-1:0]  r_cls_len;
    logic [NC_W-1:0]   r_num_clauses;
    logic [NL_W-1:0]   r_num_lits;
    logic [MV_W-1:0]   r_max_var;
    logic              r_done;
    logic              r_error;
    logic [2:0]        r_err_code;
    logic [LEN_W-1:0]  r_open_len;
    logic [LA_W-1:0]   r_open_start;

    lit_check u_chk (
        .i_literal     (load_literal),
        .i_num_lits    (r_num_lits),
        .i_num_clauses (r_num_clauses),
        .i_open_len    (r_open_len),
        .i_clause_end  (load_clause_end),
        .o_err         (w_chk_err),
        .o_abs         (w_abs)
    );

    assign w_acc    = load_valid && r_ready && (r_state == S_LOAD) && !load_clear;
    assign w_acc_ok = w_acc && (w_chk_err == ERR_NONE);

    // Open-clause length after this cycle's literal, used by start_solve
    assign w_len_nxt = !w_acc_ok       ? r_open_len :
                       load_clause_end ? '0 :
                                         r_open_len + LEN_W'(1);

    // Next state and error selection; load_clear overrides everything
    always_comb begin
        w_next = r_state;
        w_err  = ERR_NONE;
        case (r_state)
            S_LOAD: begin
                if (w_acc && w_chk_err != ERR_NONE)
                    w_err = w_chk_err;
                else if (start_solve && w_len_nxt != '0)
                    w_err = ERR_UNTERM;
                else if (start_solve)
                    w_next = S_FROZEN;
                if (w_err != ERR_NONE)
                    w_next = S_ERROR;
            end
            default: ;
        endcase
        if (load_clear) begin
            w_next = S_LOAD;
            w_err  = ERR_NONE;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_LOAD;
        else     r_state <= w_next;
    end

    // Datapath: writes, counters and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ready       <= 1'b1;
            r_lit_we      <= 1'b0;
            r_lit_waddr   <= '0;
            r_lit_wdata   <= '0;
            r_cls_we      <= 1'b0;
            r_cls_waddr   <= '0;
            r_cls_start   <= '0;
            r_cls_len     <= '0;
            r_num_clauses <= '0;
            r_num_lits    <= '0;
            r_max_var     <= '0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
            r_err_code    <= '0;
            r_open_len    <= '0;
            r_open_start  <= '0;
        end else begin
            r_lit_we <= 1'b0;
            r_cls_we <= 1'b0;
            r_ready  <= (w_next == S_LOAD);
            r_done   <= (w_next == S_FROZEN);
            if (load_clear) begin
                r_num_clauses <= '0;
                r_num_lits    <= '0;
                r_max_var     <= '0;
                r_error       <= 1'b0;
                r_err_code    <= '0;
                r_open_len    <= '0;
                r_open_start  <= '0;
            end else begin
                if (w_err != ERR_NONE) begin
                    r_error    <= 1'b1;
                    r_err_code <= w_err;
                end
                if (w_acc_ok) begin
                    r_lit_we    <= 1'b1;
                    r_lit_waddr <= r_num_lits[LA_W-1:0];
                    r_lit_wdata <= enc_lit(int'(load_literal));
                    r_num_lits  <= r_num_lits + NL_W'(1);
                    r_open_len  <= w_len_nxt;
                    if (w_abs > r_max_var)
                        r_max_var <= w_abs;
                    if (r_open_len == '0)
                        r_open_start <= r_num_lits[LA_W-1:0];
                    if (load_clause_end) begin
                        r_cls_we      <= 1'b1;
                        r_cls_waddr   <= r_num_clauses[CA_W-1:0];
                        r_cls_start   <= (r_open_len == '0) ?
                                         r_num_lits[LA_W-1:0] :
                                         r_open_start;
                        r_cls_len     <= r_open_len + LEN_W'(1);
                        r_num_clauses <= r_num_clauses + NC_W'(1);
                    end
                end
            end
        end
    end

    assign load_ready  = r_ready;
    assign lit_we      = r_lit_we;
    assign lit_waddr   = r_lit_waddr;
    assign lit_wdata   = r_lit_wdata;
    assign cls_we      = r_cls_we;
    assign cls_waddr   = r_cls_waddr;
    assign cls_start   = r_cls_start;
    assign cls_len     = r_cls_len;
    assign num_clauses = r_num_clauses;
    assign num_lits    = r_num_lits;
    assign max_var     = r_max_var;
    assign load_done   = r_done;
    assign load_error  = r_error;
    assign err_code    = r_err_code;

endmodule

// File: tb/tb_clause_load_rx.sv
// Directed bench for clause_load_rx: vector table for the basic
// load, hand sequences for errors, freeze, reset and overflow.
module tb_clause_load_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_clear;
    logic        load_valid;
    logic [31:0] load_literal;
    logic        load_clause_end;
    logic        load_ready;
    logic        start_solve;
    logic        lit_we;
    logic [10:0] lit_waddr;
    logic [8:0]  lit_wdata;
    logic        cls_we;
    logic [7:0]  cls_waddr;
    logic [10:0] cls_start;
    logic [4:0]  cls_len;
    logic [8:0]  num_clauses;
    logic [11:0] num_lits;
    logic [8:0]  max_var;
    logic        load_done;
    logic        load_error;
    logic [2:0]  err_code;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    clause_load_rx dut (
        .clk             (clk),
        .rst             (rst),
        .load_clear      (load_clear),
        .load_valid      (load_valid),
        .load_literal    (load_literal),
        .load_clause_end (load_clause_end),
        .load_ready      (load_ready),
        .start_solve     (start_solve),
        .lit_we          (lit_we),
        .lit_waddr       (lit_waddr),
        .lit_wdata       (lit_wdata),
        .cls_we          (cls_we),
        .cls_waddr       (cls_waddr),
        .cls_start       (cls_start),
        .cls_len         (cls_len),
        .num_clauses     (num_clauses),
        .num_lits        (num_lits),
        .max_var         (max_var),
        .load_done       (load_done),
        .load_error      (load_error),
        .err_code        (err_code)
    );

    typedef struct {
        logic v;
        int   lit;
        logic ce;
        logic ss;
        logic e_lwe;
        int   e_wa;
        int   e_wd;
        logic e_cwe;
        int   e_ca;
        int   e_cs;
        int   e_cl;
    } vec_t;

    vec_t tv[4];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input logic v, input int lit, input logic ce,
                        input logic ss, input logic clr);
        @(negedge clk);
        load_valid      = v;
        load_literal    = lit;
        load_clause_end = ce;
        start_solve     = ss;
        load_clear      = clr;
        @(posedge clk);
        #1;
        load_valid      = 1'b0;
        load_literal    = 32'd0;
        load_clause_end = 1'b0;
        start_solve     = 1'b0;
        load_clear      = 1'b0;
    endtask

    initial begin
        int wcnt;
        rst             = 1'b1;
        load_clear      = 1'b0;
        load_valid      = 1'b0;
        load_literal    = 32'd0;
        load_clause_end = 1'b0;
        start_solve     = 1'b0;

        tv[0] = '{1'b1,  1, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 0, 0, 0};
        tv[1] = '{1'b1, -2, 1'b1, 1'b0, 1'b1, 1, 3, 1'b1, 0, 0, 2};
        tv[2] = '{1'b1,  3, 1'b1, 1'b0, 1'b1, 2, 4, 1'b1, 1, 2, 1};
        tv[3] = '{1'b0,  0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 0};

        #12;
        chk("rst_ready", load_ready, 1);
        chk("rst_nlits", num_lits, 0);
        chk("rst_done", load_done, 0);
        chk("rst_err", load_error, 0);
        @(negedge clk);
        rst = 1'b0;

        // (1 -2 0)(3 0) then start_solve
        for (int i = 0; i < 4; i++) begin
            step(tv[i].v, tv[i].lit, tv[i].ce, tv[i].ss, 1'b0);
            chk($sformatf("t1_lwe%0d", i), lit_we, tv[i].e_lwe);
            chk($sformatf("t1_cwe%0d", i), cls_we, tv[i].e_cwe);
            if (tv[i].e_lwe) begin
                chk($sformatf("t1_wa%0d", i), lit_waddr, tv[i].e_wa);
                chk($sformatf("t1_wd%0d", i), lit_wdata, tv[i].e_wd);
            end
            if (tv[i].e_cwe) begin
                chk($sformatf("t1_ca%0d", i), cls_waddr, tv[i].e_ca);
                chk($sformatf("t1_cs%0d", i), cls_start, tv[i].e_cs);
                chk($sformatf("t1_cl%0d", i), cls_len, tv[i].e_cl);
            end
        end
        chk("t1_done", load_done, 1);
        chk("t1_ncls", num_clauses, 2);
        chk("t1_maxv", max_var, 3);
        chk("t1_nlits", num_lits, 3);
        chk("t1_ready", load_ready, 0);

        // frozen: held valid must not write
        wcnt = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 9, 1'b1, 1'b0, 1'b0);
            wcnt += int'(lit_we) + int'(cls_we);
        end
        chk("t5_frz_writes", wcnt, 0);
        chk("t5_frz_nlits", num_lits, 3);
        chk("t5_frz_done", load_done, 1);

        // out-of-range literal
        step(1'b0, 0, 1'b0, 1'b0, 1'b1);
        chk("t2_clr_done", load_done, 0);
        step(1'b1, 300, 1'b1, 1'b0, 1'b0);
        chk("t2_lwe", lit_we, 0);
        chk("t2_err", load_error, 1);
        chk("t2_code", err_code, 2);
        chk("t2_ready", load_ready, 0);
        step(1'b0, 0, 1'b0, 1'b0, 1'b1);
        chk("t2_clr_ready", load_ready, 1);
        chk("t2_clr_nlits", num_lits, 0);
        chk("t2_clr_ncls", num_clauses, 0);
        chk("t2_clr_err", load_error, 0);

        // zero literal and -2^31
        step(1'b1, 0, 1'b0, 1'b0, 1'b0);
        chk("zero_code", err_code, 1);
        step(1'b0, 0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        chk("min_code", err_code, 2);
        chk("min_lwe", lit_we, 0);
        step(1'b0, 0, 1'b0, 1'b0, 1'b1);

        // 17-literal clause
        wcnt = 0;
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, i, 1'b0, 1'b0, 1'b0);
            wcnt += int'(lit_we);
        end
        chk("t3_writes", wcnt, 16);
        chk("t3_maxv", max_var, 16);
        step(1'b1, 17, 1'b1, 1'b0, 1'b0);
        chk("t3_lwe", lit_we, 0);
        chk("t3_cwe", cls_we, 0);
        chk("t3_code", err_code, 4);
        chk("t3_nlits", num_lits, 16);
        step(1'b0, 0, 1'b0, 1'b0, 1'b1);

        // unterminated clause at start_solve
        step(1'b1, 5, 1'b0, 1'b0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b1, 1'b0);
        chk("t4_code", err_code, 6);
        chk("t4_done", load_done, 0);
        step(1'b0, 0, 1'b0, 1'b0, 1'b1);

        // clause_end and start_solve together
        step(1'b1, -5, 1'b1, 1'b1, 1'b0);
        chk("t4b_cwe", cls_we, 1);
        chk("t4b_clen", cls_len, 1);
        chk("t4b_wd", lit_wdata, 9);
        chk("t4b_done", load_done, 1);
        chk("t4b_ncls", num_clauses, 1);
        chk("t4b_err", load_error, 0);
        step(1'b0, 0, 1'b0, 1'b0, 1'b1);

        // start_solve with nothing loaded
        step(1'b0, 0, 1'b0, 1'b1, 1'b0);
        chk("empty_done", load_done, 1);
        chk("empty_ncls", num_clauses, 0);
        step(1'b0, 0, 1'b0, 1'b0, 1'b1);

        // async reset mid-clause
        step(1'b1, 4, 1'b0, 1'b0, 1'b0);
        chk("t5_pre_lwe", lit_we, 1);
        rst = 1'b1;
        #1;
        chk("t5_rst_lwe", lit_we, 0);
        chk("t5_rst_nlits", num_lits, 0);
        chk("t5_rst_maxv", max_var, 0);
        chk("t5_rst_ready", load_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 2, 1'b1, 1'b0, 1'b0);
        chk("t5_after_cs", cls_start, 0);
        chk("t5_after_cl", cls_len, 1);
        step(1'b0, 0, 1'b0, 1'b0, 1'b1);

        // fill clause table with unit clauses
        wcnt = 0;
        for (int i = 0; i < 256; i++) begin
            step(1'b1, (i % 200) + 1, 1'b1, 1'b0, 1'b0);
            wcnt += int'(cls_we);
        end
        chk("t6_cwes", wcnt, 256);
        chk("t6_last_ca", cls_waddr, 255);
        chk("t6_last_cs", cls_start, 255);
        chk("t6_ncls", num_clauses, 256);
        chk("t6_maxv", max_var, 200);
        step(1'b1, 7, 1'b1, 1'b0, 1'b0);
        chk("t6_cwe", cls_we, 0);
        chk("t6_code", err_code, 5);
        chk("t6_ncls_hold", num_clauses, 256);
        chk("t6_nlits_hold", num_lits, 256);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
